sb_prefetch_ctrl: RTL and testbench

//  Sequential next-line prefetch controller placed directly upstream of stream_buffer.

---
 rtl/sb_prefetch_ctrl_pkg.sv | 15 +
 rtl/sb_prefetch_ctrl_if.sv | 34 +++
 rtl/sb_prefetch_ctrl_label_next.sv | 18 +
 rtl/sb_prefetch_ctrl.sv | 77 +++++++
 tb/tb_sb_prefetch_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sb_prefetch_ctrl_pkg.sv
// sb_prefetch_ctrl_pkg: shared types for the stream-buffer prefetch controller.
package sb_prefetch_ctrl_pkg;
  typedef logic [31:0] phys_t;
  typedef enum logic [2:0] {
    C_IDLE,
    C_CHECK,
    C_WAIT,
    C_HIT_RESP,
    C_MISS_RESP,
    C_PREFETCH
  } sb_ctrl_state_t;
  function automatic int label_width(input int line_width);
    return $bits(phys_t) - $clog2(line_width / 8);
  endfunction
endpackage

// File: rtl/sb_prefetch_ctrl_if.sv
// sb_prefetch_ctrl_if: miss-lookup and stream-buffer signals of the prefetch controller.
interface sb_prefetch_ctrl_if #(
  parameter int LINE_WIDTH = 256,
  parameter int DATA_WIDTH = 32
);
  import sb_prefetch_ctrl_pkg::*;
  localparam int LABEL_WIDTH = label_width(LINE_WIDTH);
  localparam int WORDS = LINE_WIDTH / DATA_WIDTH;
  logic [LABEL_WIDTH-1:0] req_label;
  logic                   req_vld;
  logic                   req_rdy;
  logic                   flush;
  logic                   resp_vld;
  logic                   resp_hit;
  logic [LINE_WIDTH-1:0]  resp_line;
  logic [LABEL_WIDTH-1:0] sb_label_i;
  logic                   sb_label_i_rdy;
  logic                   sb_inv;
  logic                   sb_write;
  logic                   sb_hit;
  logic [LABEL_WIDTH-1:0] sb_label_o;
  logic                   sb_label_o_vld;
  logic [LINE_WIDTH-1:0]  sb_data;
  logic [WORDS-1:0]       sb_data_vld;
  logic                   sb_idle;
  modport slave (
    input  req_label, req_vld, flush, sb_label_o, sb_label_o_vld, sb_data, sb_data_vld, sb_idle,
    output req_rdy, resp_vld, resp_hit, resp_line, sb_label_i, sb_label_i_rdy, sb_inv, sb_write, sb_hit
  );
  modport master (
    output req_label, req_vld, flush, sb_label_o, sb_label_o_vld, sb_data, sb_data_vld, sb_idle,
    input  req_rdy, resp_vld, resp_hit, resp_line, sb_label_i, sb_label_i_rdy, sb_inv, sb_write, sb_hit
  );
endinterface

// File: rtl/sb_prefetch_ctrl_label_next.sv
// sb_label_next: next-line label (wrapping) and page-crossing suppress flag.
// The suppress flag is only active when SB_PAGE_GUARD_EN is defined.
module sb_label_next #(
  parameter int LABEL_WIDTH = 27,
  parameter int GUARD_BITS  = 7
) (
  input  logic [LABEL_WIDTH-1:0] i_label,
  output logic [LABEL_WIDTH-1:0] o_next,
  output logic                   o_skip
);
`ifdef SB_PAGE_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif
  assign o_next = i_label + LABEL_WIDTH'(1);
  assign o_skip = GUARD_ON & ~|o_next[GUARD_BITS-1:0];
endmodule

// File: rtl/sb_prefetch_ctrl.sv
// sb_prefetch_ctrl: next-line prefetch controller in front of the stream buffer.
// Optional page guard (no prefetch across a page boundary) enabled by SB_PAGE_GUARD_EN.
module sb_prefetch_ctrl
  import sb_prefetch_ctrl_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int DATA_WIDTH = 32,
  parameter int PAGE_BITS  = 12
) (
  input logic           clk,
  input logic           rst_n,
  sb_prefetch_ctrl_if.slave bus
);
  localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int LABEL_WIDTH = $bits(phys_t) - LINE_BYTE_OFFSET;
  localparam int WORDS = LINE_WIDTH / DATA_WIDTH;
  sb_ctrl_state_t         r_state;
  logic [LABEL_WIDTH-1:0] r_label;
  logic [LABEL_WIDTH-1:0] r_next;
  logic                   r_skip;
  logic [LINE_WIDTH-1:0]  r_line;
  logic [LABEL_WIDTH-1:0] w_next;
  logic                   w_skip;
  logic [WORDS-1:0]       w_dvld;
  logic                   w_match;
  logic                   w_full;
  assign w_dvld  = bus.sb_data_vld;
  assign w_full  = &w_dvld;
  assign w_match = bus.sb_label_o_vld & (bus.sb_label_o == r_label);
  sb_label_next #(
    .LABEL_WIDTH(LABEL_WIDTH),
    .GUARD_BITS (PAGE_BITS - LINE_BYTE_OFFSET)
  ) u_next (
    .i_label(r_label),
    .o_next (w_next),
    .o_skip (w_skip)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
      r_label <= '0;
      r_next  <= '0;
      r_skip  <= 1'b0;
      r_line  <= '0;
    end else if (bus.flush) begin
      r_state <= C_IDLE;
    end else begin
      case (r_state)
        C_IDLE: if (bus.req_vld) begin
          r_label <= bus.req_label;
          r_state <= C_CHECK;
        end
        // A line that stops matching while we wait is treated as a miss
        C_CHECK, C_WAIT: begin
          r_state <= !w_match ? C_MISS_RESP : w_full ? C_HIT_RESP : C_WAIT;
          if (w_match && w_full) r_line <= bus.sb_data;
        end
        C_HIT_RESP, C_MISS_RESP: begin
          r_next  <= w_next;
          r_skip  <= w_skip;
          r_state <= C_PREFETCH;
        end
        C_PREFETCH: if (bus.sb_idle) r_state <= C_IDLE;
        default: r_state <= C_IDLE;
      endcase
    end
  end
  assign bus.req_rdy        = (r_state == C_IDLE) & ~bus.flush;
  assign bus.resp_vld       = ((r_state == C_HIT_RESP) | (r_state == C_MISS_RESP)) & ~bus.flush;
  assign bus.resp_hit       = (r_state == C_HIT_RESP) & ~bus.flush;
  assign bus.resp_line      = r_line;
  assign bus.sb_write       = (r_state == C_HIT_RESP) & ~bus.flush;
  assign bus.sb_inv         = (r_state == C_MISS_RESP) | bus.flush;
  assign bus.sb_hit         = r_state == C_WAIT;
  assign bus.sb_label_i     = r_next;
  assign bus.sb_label_i_rdy = (r_state == C_PREFETCH) & bus.sb_idle & ~bus.sb_inv & ~r_skip;
endmodule

// File: tb/tb_sb_prefetch_ctrl.sv
// tb_sb_prefetch_ctrl: table-driven lookups plus hand-written flush/wait/reset sequences.
module tb_sb_prefetch_ctrl;
  import sb_prefetch_ctrl_pkg::*;
`ifdef SB_PAGE_GUARD_EN
  localparam bit PG = 1'b1;
`else
  localparam bit PG = 1'b0;
`endif
  typedef struct {
    logic [26:0] sb_lbl;
    logic        sb_vld;
    logic [7:0]  dvld;
    logic [26:0] req;
    int          idle_wait;
    logic        exp_hit;
    logic        exp_pf;
    logic [26:0] exp_next;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [255:0] line_pat;
  vec_t vecs[5];
  always #5 clk = ~clk;
  sb_prefetch_ctrl_if #(.LINE_WIDTH(256), .DATA_WIDTH(32)) bus ();
  sb_prefetch_ctrl #(.LINE_WIDTH(256), .DATA_WIDTH(32), .PAGE_BITS(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic start(input logic [26:0] lbl, input logic [7:0] dv);
    bus.sb_label_o = lbl;
    bus.sb_label_o_vld = 1'b1;
    bus.sb_data_vld = dv;
    bus.sb_idle = 1'b1;
    bus.req_label = lbl;
    bus.req_vld = 1'b1;
    step();
    bus.req_vld = 1'b0;
  endtask
  task automatic run_txn(input vec_t v);
    bus.sb_label_o = v.sb_lbl;
    bus.sb_label_o_vld = v.sb_vld;
    bus.sb_data_vld = v.dvld;
    bus.sb_idle = (v.idle_wait == 0);
    bus.req_label = v.req;
    bus.req_vld = 1'b1;
    #1 chk("req_rdy_idle", bus.req_rdy, 1);
    step();
    bus.req_vld = 1'b0;
    #1 chk("resp_early", bus.resp_vld, 0);
    step();
    #1 chk("resp_vld", bus.resp_vld, 1);
    chk("resp_hit", bus.resp_hit, v.exp_hit);
    chk("sb_write", bus.sb_write, v.exp_hit);
    chk("sb_inv", bus.sb_inv, !v.exp_hit);
    if (v.exp_hit) chk("resp_line", bus.resp_line, line_pat);
    for (int i = 0; i < v.idle_wait; i++) begin
      step();
      #1 chk("pf_busy", bus.sb_label_i_rdy, 0);
    end
    step();
    bus.sb_idle = 1'b1;
    #1 chk("pf_rdy", bus.sb_label_i_rdy, v.exp_pf);
    if (v.exp_pf) chk("pf_label", bus.sb_label_i, v.exp_next);
    step();
    #1 chk("back_idle", bus.req_rdy, 1);
    chk("pf_once", bus.sb_label_i_rdy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8; i++) line_pat[i*32+:32] = 32'hC0DE_0000 + i;
    vecs[0] = '{27'h0001000, 1'b1, 8'hFF, 27'h0001000, 0, 1'b1, 1'b1, 27'h0001001};
    vecs[1] = '{27'h0000042, 1'b1, 8'hFF, 27'h0000100, 2, 1'b0, 1'b1, 27'h0000101};
    vecs[2] = '{27'h0000042, 1'b1, 8'hFF, 27'h7FFFFFF, 0, 1'b0, 1'b1, 27'h0000000};
    vecs[3] = '{27'h0000200, 1'b0, 8'hFF, 27'h0000200, 1, 1'b0, 1'b1, 27'h0000201};
    vecs[4] = '{27'h000007F, 1'b1, 8'hFF, 27'h000007F, 0, 1'b1, !PG, 27'h0000080};
    bus.sb_data = line_pat;
    bus.sb_label_o = '0;
    bus.sb_label_o_vld = 1'b0;
    bus.sb_data_vld = '0;
    bus.sb_idle = 1'b1;
    bus.req_label = '0;
    bus.req_vld = 1'b0;
    bus.flush = 1'b0;
    step();
    step();
    #1 chk("rst_req_rdy", bus.req_rdy, 1);
    chk("rst_resp_vld", bus.resp_vld, 0);
    chk("rst_sb_inv", bus.sb_inv, 0);
    chk("rst_pf_rdy", bus.sb_label_i_rdy, 0);
    chk("rst_sb_hit", bus.sb_hit, 0);
    chk("rst_sb_write", bus.sb_write, 0);
    chk("rst_label_i", bus.sb_label_i, 0);
    chk("rst_line", bus.resp_line, 0);
    rst_n = 1'b1;
    step();
    foreach (vecs[k]) run_txn(vecs[k]);
    // partial line: three cycles of sb_hit before the line completes
    start(27'h0001000, 8'h0F);
    #1 chk("part_check_nohit", bus.sb_hit, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 chk("part_sb_hit", bus.sb_hit, 1);
      chk("part_no_resp", bus.resp_vld, 0);
    end
    bus.sb_data_vld = 8'hFF;
    step();
    #1 chk("part_resp_vld", bus.resp_vld, 1);
    chk("part_resp_hit", bus.resp_hit, 1);
    chk("part_hit_off", bus.sb_hit, 0);
    step();
    #1 chk("part_pf_rdy", bus.sb_label_i_rdy, 1);
    chk("part_pf_label", bus.sb_label_i, 27'h0001001);
    step();
    // flush while waiting
    start(27'h0002000, 8'h0F);
    step();
    bus.flush = 1'b1;
    bus.sb_data_vld = 8'hFF;
    #1 chk("fl_sb_inv", bus.sb_inv, 1);
    chk("fl_no_resp", bus.resp_vld, 0);
    chk("fl_req_rdy_low", bus.req_rdy, 0);
    step();
    bus.flush = 1'b0;
    #1 chk("fl_req_rdy", bus.req_rdy, 1);
    chk("fl_no_resp2", bus.resp_vld, 0);
    step();
    #1 chk("fl_no_resp3", bus.resp_vld, 0);
    chk("fl_no_pf", bus.sb_label_i_rdy, 0);
    // flush together with a request: not accepted
    bus.sb_label_o = 27'h0003000;
    bus.req_label = 27'h0003000;
    bus.req_vld = 1'b1;
    bus.flush = 1'b1;
    #1 chk("flreq_rdy", bus.req_rdy, 0);
    step();
    bus.flush = 1'b0;
    bus.req_vld = 1'b0;
    step();
    #1 chk("flreq_no_resp", bus.resp_vld, 0);
    chk("flreq_idle", bus.req_rdy, 1);
    // line label changes while waiting -> miss
    start(27'h0004000, 8'h0F);
    step();
    bus.sb_label_o = 27'h0001234;
    step();
    #1 chk("chg_resp_vld", bus.resp_vld, 1);
    chk("chg_resp_hit", bus.resp_hit, 0);
    chk("chg_sb_inv", bus.sb_inv, 1);
    step();
    #1 chk("chg_pf_label", bus.sb_label_i, 27'h0004001);
    chk("chg_pf_rdy", bus.sb_label_i_rdy, 1);
    step();
    // async reset mid-transaction
    start(27'h0005000, 8'h0F);
    step();
    #1 chk("ar_waiting", bus.sb_hit, 1);
    rst_n = 1'b0;
    #1 chk("ar_no_inv", bus.sb_inv, 0);
    chk("ar_sb_hit", bus.sb_hit, 0);
    chk("ar_req_rdy", bus.req_rdy, 1);
    rst_n = 1'b1;
    bus.sb_data_vld = 8'hFF;
    step();
    #1 chk("ar_no_resp", bus.resp_vld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
